// File: rtl/uart_pkg.sv
// Shared UART receiver definitions: FSM state encoding and parity mode codes.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP1,
        ST_STOP2,
        ST_BREAK_WAIT
    } rx_state_t;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    function automatic logic parity_enabled(input logic [1:0] mode);
        return (mode == PAR_EVEN) || (mode == PAR_ODD);
    endfunction

endpackage

// File: rtl/uart_os_tick_gen.sv
// Oversample tick generator: one-clk pulse every max(div,1) clks, realigned by restart.
module uart_os_tick_gen #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             restart,
    input  logic [DIV_W-1:0] div,
    output logic             os_tick
);

    logic [DIV_W-1:0] r_cnt;
    logic [DIV_W-1:0] w_last;

    assign w_last  = (div == '0) ? '0 : div - DIV_W'(1);
    // >= keeps the period bounded if div shrinks below the running count
    assign os_tick = (r_cnt >= w_last);

    always_ff @(posedge clk) begin
        if (reset || restart)
            r_cnt <= '0;
        else if (os_tick)
            r_cnt <= '0;
        else
            r_cnt <= r_cnt + DIV_W'(1);
    end

endmodule

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver with parity, 1/2 stop bits, break detect and
// a single-entry valid/ready output register.
module uart_rx_os
    import uart_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int OS     = 16,
    parameter int DIV_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx_in,
    input  logic [DIV_W-1:0]  div,
    input  logic [1:0]        parity_mode,
    input  logic              stop2,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic              parity_error,
    output logic              framing_error,
    output logic              overrun,
    output logic              break_det
);

    localparam int OSC_W = $clog2(OS);
    localparam int BIT_W = $clog2(DATA_W);
    localparam logic [OSC_W-1:0] HALF_M1 = OSC_W'(OS / 2 - 1);
    localparam logic [OSC_W-1:0] FULL_M1 = OSC_W'(OS - 1);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);

    logic              r_sync1, r_sync2, r_rx_prev;
    rx_state_t         r_state;
    logic [OSC_W-1:0]  r_os_cnt;
    logic [BIT_W-1:0]  r_bit_idx;
    logic [DATA_W-1:0] r_shift;
    logic              r_par_acc, r_all_zero;
    logic              r_par_en, r_par_odd, r_stop2;
    logic [DIV_W-1:0]  r_div;
    logic [DATA_W-1:0] r_rx_data;
    logic              r_rx_valid, r_parity_error, r_framing_error, r_overrun, r_break_det;

    logic w_rx, w_fall, w_restart, w_tick, w_sample, w_word_done, w_new_perr;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1   <= 1'b1;
            r_sync2   <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_sync1   <= rx_in;
            r_sync2   <= r_sync1;
            r_rx_prev <= r_sync2;
        end
    end

    assign w_rx        = r_sync2;
    assign w_fall      = r_rx_prev & ~w_rx;
    assign w_restart   = (r_state == ST_IDLE) && w_fall;
    assign w_sample    = w_tick && ((r_state == ST_START) ? (r_os_cnt == HALF_M1)
                                                          : (r_os_cnt == FULL_M1));
    assign w_word_done = w_sample && w_rx &&
                         (((r_state == ST_STOP1) && !r_stop2) || (r_state == ST_STOP2));
    // accumulator holds XOR of data and parity bit; odd mode expects it set
    assign w_new_perr  = r_par_en & (r_par_acc ^ r_par_odd);

    uart_os_tick_gen #(.DIV_W(DIV_W)) u_tick (
        .clk     (clk),
        .reset   (reset),
        .restart (w_restart),
        .div     (r_div),
        .os_tick (w_tick)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state         <= ST_IDLE;
            r_os_cnt        <= '0;
            r_bit_idx       <= '0;
            r_shift         <= '0;
            r_par_acc       <= 1'b0;
            r_all_zero      <= 1'b0;
            r_par_en        <= 1'b0;
            r_par_odd       <= 1'b0;
            r_stop2         <= 1'b0;
            r_div           <= '0;
            r_rx_data       <= '0;
            r_rx_valid      <= 1'b0;
            r_parity_error  <= 1'b0;
            r_framing_error <= 1'b0;
            r_overrun       <= 1'b0;
            r_break_det     <= 1'b0;
        end else begin
            r_framing_error <= 1'b0;
            r_overrun       <= 1'b0;
            r_break_det     <= 1'b0;

            if (w_tick)
                r_os_cnt <= w_sample ? '0 : r_os_cnt + OSC_W'(1);

            case (r_state)
                ST_IDLE: begin
                    r_os_cnt <= '0;
                    if (w_fall) begin
                        r_state    <= ST_START;
                        r_bit_idx  <= '0;
                        r_par_acc  <= 1'b0;
                        r_all_zero <= 1'b1;
                        r_par_en   <= parity_enabled(parity_mode);
                        r_par_odd  <= (parity_mode == PAR_ODD);
                        r_stop2    <= stop2;
                        r_div      <= div;
                    end
                end
                ST_START:
                    if (w_sample) r_state <= w_rx ? ST_IDLE : ST_DATA;
                ST_DATA:
                    if (w_sample) begin
                        r_shift    <= {w_rx, r_shift[DATA_W-1:1]};
                        r_par_acc  <= r_par_acc ^ w_rx;
                        r_all_zero <= r_all_zero & ~w_rx;
                        if (r_bit_idx == LAST_BIT)
                            r_state <= r_par_en ? ST_PARITY : ST_STOP1;
                        else
                            r_bit_idx <= r_bit_idx + BIT_W'(1);
                    end
                ST_PARITY:
                    if (w_sample) begin
                        r_par_acc  <= r_par_acc ^ w_rx;
                        r_all_zero <= r_all_zero & ~w_rx;
                        r_state    <= ST_STOP1;
                    end
                ST_STOP1:
                    if (w_sample) begin
                        if (!w_rx && r_all_zero) begin
                            r_break_det <= 1'b1;
                            r_state     <= ST_BREAK_WAIT;
                        end else if (!w_rx) begin
                            r_framing_error <= 1'b1;
                            r_state         <= ST_IDLE;
                        end else begin
                            r_state <= r_stop2 ? ST_STOP2 : ST_IDLE;
                        end
                    end
                ST_STOP2:
                    if (w_sample) begin
                        r_framing_error <= ~w_rx;
                        r_state         <= ST_IDLE;
                    end
                ST_BREAK_WAIT:
                    if (w_rx) r_state <= ST_IDLE;
                default:
                    r_state <= ST_IDLE;
            endcase

            // an unconsumed word wins over a completing one unless it is taken this clk
            if (w_word_done) begin
                if (r_rx_valid && !rx_ready) begin
                    r_overrun <= 1'b1;
                end else begin
                    r_rx_valid     <= 1'b1;
                    r_rx_data      <= r_shift;
                    r_parity_error <= w_new_perr;
                end
            end else if (r_rx_valid && rx_ready) begin
                r_rx_valid <= 1'b0;
            end
        end
    end

    assign rx_data       = r_rx_data;
    assign rx_valid      = r_rx_valid;
    assign parity_error  = r_parity_error;
    assign framing_error = r_framing_error;
    assign overrun       = r_overrun;
    assign break_det     = r_break_det;

endmodule

// File: tb/tb_uart_rx_os.sv
// Frame-level reference model for uart_rx_os: drives whole serial frames and
// predicts loaded words and error/overrun/break pulses per frame.
module tb_uart_rx_os;
    import uart_pkg::*;

    localparam int DW   = 8;
    localparam int DIVW = 16;
    localparam int BIT  = 64;

    logic            clk = 1'b0, reset = 1'b1, rx_in = 1'b1, stop2 = 1'b0, rx_ready = 1'b0;
    logic [DIVW-1:0] div = 16'd4;
    logic [1:0]      parity_mode = PAR_NONE;
    logic [DW-1:0]   rx_data;
    logic            rx_valid, parity_error, framing_error, overrun, break_det;

    always #5 clk = ~clk;

    uart_rx_os #(.DATA_W(DW), .OS(16), .DIV_W(DIVW)) dut (
        .clk(clk), .reset(reset), .rx_in(rx_in), .div(div),
        .parity_mode(parity_mode), .stop2(stop2),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .parity_error(parity_error), .framing_error(framing_error),
        .overrun(overrun), .break_det(break_det)
    );

    int checks = 0, passes = 0;
    int n_load = 0, n_ferr = 0, n_brk = 0, n_ovr = 0;
    logic [8:0]    exp_q[$];
    logic          m_valid = 1'b0, m_perr = 1'b0;
    logic [DW-1:0] m_data = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Monitor: counts pulse cycles, matches each load to the model queue, and
    // checks the output register stays frozen while stalled.
    logic          p_valid = 1'b0, p_ready = 1'b0, p_reset = 1'b1;
    logic [DW-1:0] p_data = '0;
    logic [8:0]    mon_e;
    always @(negedge clk) begin
        if (!reset && !p_reset) begin
            if (framing_error) n_ferr++;
            if (break_det)     n_brk++;
            if (overrun)       n_ovr++;
            if (rx_valid && (!p_valid || p_ready)) begin
                n_load++;
                chk("load_expected", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    mon_e = exp_q.pop_front();
                    chk("load_data", rx_data, mon_e[7:0]);
                    chk("load_perr", parity_error, mon_e[8]);
                end
            end
            if (p_valid && !p_ready) begin
                chk("hold_valid", rx_valid, 1);
                chk("hold_data", rx_data, p_data);
            end
        end
        p_valid = rx_valid;
        p_ready = rx_ready;
        p_reset = reset;
        p_data  = rx_data;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_deltas(input string tag, input int cl, input int cf, input int cb, input int co,
                              input int el, input int ef, input int eb, input int eo);
        chk({tag, "_loads"}, n_load - cl, el);
        chk({tag, "_ferr"},  n_ferr - cf, ef);
        chk({tag, "_break"}, n_brk - cb,  eb);
        chk({tag, "_ovr"},   n_ovr - co,  eo);
        chk({tag, "_valid"}, rx_valid, m_valid);
        if (m_valid) begin
            chk({tag, "_held_data"}, rx_data, m_data);
            chk({tag, "_held_perr"}, parity_error, m_perr);
        end
    endtask

    // bad: 0 none, 1 first stop low, 2 second stop low (only with s2)
    task automatic send_frame(input logic [7:0] d, input logic [1:0] pm, input logic s2,
                              input logic par_ok, input int bad, input logic rdy,
                              input logic rdy_late, input logic scramble, input int gap);
        logic np, pb, perr, rdy_at_end;
        int   kind, cl, cf, cb, co, el, ef, eb, eo;
        np   = (pm == PAR_EVEN) || (pm == PAR_ODD);
        pb   = (pm == PAR_ODD) ? ~(^d) : (^d);
        if (!par_ok) pb = ~pb;
        perr = (pm == PAR_EVEN) ? (^d ^ pb) : (pm == PAR_ODD) ? ~(^d ^ pb) : 1'b0;
        if (bad == 1)             kind = (d == 0 && (!np || !pb)) ? 2 : 1;
        else if (bad == 2 && s2)  kind = 1;
        else                      kind = 0;
        rdy_at_end = rdy || rdy_late;
        el = 0; ef = (kind == 1) ? 1 : 0; eb = (kind == 2) ? 1 : 0; eo = 0;
        if (kind == 0) begin
            if (!rdy_at_end && m_valid) eo = 1;
            else begin
                el = 1;
                exp_q.push_back({perr, d});
                m_valid = 1'b1; m_data = d; m_perr = perr;
            end
        end
        if (rdy_at_end) m_valid = 1'b0;
        cl = n_load; cf = n_ferr; cb = n_brk; co = n_ovr;

        rx_ready = rdy; parity_mode = pm; stop2 = s2;
        rx_in = 1'b0;
        if (scramble) begin
            tick(6);
            parity_mode = 2'($urandom_range(0, 3));
            stop2 = 1'($urandom_range(0, 1));
            div = 16'($urandom_range(1, 9));
            tick(BIT - 6);
        end else tick(BIT);
        for (int i = 0; i < DW; i++) begin rx_in = d[i]; tick(BIT); end
        if (np) begin rx_in = pb; tick(BIT); end
        rx_in = (bad != 1);
        if (rdy_late) rx_ready = 1'b1;
        tick(BIT);
        if (s2) begin rx_in = (bad != 2); tick(BIT); end
        rx_in = 1'b1; div = 16'd4;
        tick(gap + 3);
        chk_deltas("frame", cl, cf, cb, co, el, ef, eb, eo);
    endtask

    task automatic consume();
        rx_ready = 1'b1; tick(1);
        rx_ready = 1'b0; tick(1);
        chk("consume_valid", rx_valid, 0);
        m_valid = 1'b0;
    endtask

    initial begin
        int cl, cf, cb, co;
        tick(5);
        chk("rst_valid", rx_valid, 0);
        chk("rst_data", rx_data, 0);
        chk("rst_perr", parity_error, 0);
        chk("rst_pulses", {framing_error, overrun, break_det}, 0);
        reset = 1'b0; tick(20);

        // even parity, correct, held until consumed
        send_frame(8'hA5, PAR_EVEN, 0, 1, 0, 0, 0, 0, 20);
        chk("a5_data", rx_data, 8'hA5);
        chk("a5_perr", parity_error, 0);
        tick(50);
        chk("a5_still_valid", rx_valid, 1);
        chk("a5_still_data", rx_data, 8'hA5);
        consume();

        // odd parity with inverted parity bit
        send_frame(8'h3C, PAR_ODD, 0, 0, 0, 0, 0, 0, 20);
        chk("3c_data", rx_data, 8'h3C);
        chk("3c_perr", parity_error, 1);
        consume();

        // 20-clk glitch
        cl = n_load; cf = n_ferr; cb = n_brk; co = n_ovr;
        rx_in = 1'b0; tick(20); rx_in = 1'b1; tick(2 * BIT);
        chk_deltas("glitch", cl, cf, cb, co, 0, 0, 0, 0);

        // framing error, then break
        send_frame(8'h55, PAR_NONE, 0, 1, 1, 0, 0, 0, 20);
        chk("55_valid", rx_valid, 0);
        cl = n_load; cf = n_ferr; cb = n_brk; co = n_ovr;
        rx_in = 1'b0; tick(12 * BIT); rx_in = 1'b1; tick(100);
        chk_deltas("break", cl, cf, cb, co, 0, 0, 1, 0);

        // overrun keeps the old word
        send_frame(8'h11, PAR_NONE, 0, 1, 0, 0, 0, 0, 5);
        send_frame(8'h22, PAR_NONE, 0, 1, 0, 0, 0, 0, 5);
        chk("ovr_keeps_old", rx_data, 8'h11);
        consume();
        // ready raised before completion: new word taken, no overrun
        send_frame(8'h11, PAR_NONE, 0, 1, 0, 0, 0, 0, 5);
        send_frame(8'h22, PAR_NONE, 0, 1, 0, 0, 1, 0, 5);
        chk("ready_new_word", rx_data, 8'h22);
        rx_ready = 1'b0;

        // reset mid DATA, then a two-stop-bit frame
        cl = n_load; cf = n_ferr; cb = n_brk; co = n_ovr;
        rx_in = 1'b0; tick(BIT);
        rx_in = 1'b1; tick(3 * BIT);
        reset = 1'b1; tick(3); reset = 1'b0;
        m_valid = 1'b0; exp_q.delete();
        tick(2 * BIT);
        chk_deltas("reset_mid", cl, cf, cb, co, 0, 0, 0, 0);
        chk("reset_mid_data", rx_data, 0);
        send_frame(8'h81, PAR_NONE, 1, 1, 0, 0, 0, 0, 10);
        chk("81_data", rx_data, 8'h81);
        consume();

        // randomized frames with config scrambled mid-frame
        for (int k = 0; k < 30; k++) begin
            logic [7:0] d;
            logic [1:0] pm;
            logic s2, pok, rdy, late;
            int b, r;
            d   = 8'($urandom);
            pm  = 2'($urandom_range(0, 3));
            s2  = 1'($urandom_range(0, 1));
            pok = ($urandom_range(0, 3) != 0);
            r   = $urandom_range(0, 7);
            b   = (r == 0) ? 1 : (r == 1 && s2) ? 2 : 0;
            rdy = 1'($urandom_range(0, 1));
            late = !rdy && ($urandom_range(0, 3) == 0);
            send_frame(d, pm, s2, pok, b, rdy, late, 1, $urandom_range(0, 40));
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
